// File: rtl/host_msg_handler_pkg.sv
// Shared message codes, FSM state encoding and size helpers for the host
// message handler.
package host_msg_handler_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam int RESULT_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HDR,
    LOAD,
    DECODE,
    RESULT
  } state_e;

  function automatic int bytes_for_bits(input int n_bits);
    return (n_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Three-byte load-and-shift serializer: holds a result word and presents it
// MSB byte first on a valid/ready byte stream.
module result_serializer
  import host_msg_handler_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [23:0] data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        done_o
);

  logic [23:0] shreg_q;
  logic [1:0]  idx_q;
  logic        valid_q;
  logic        fire;
  logic        last_byte;

  assign fire      = valid_q & ready_i;
  assign last_byte = (idx_q == 2'(RESULT_BYTES - 1));
  assign done_o    = fire & last_byte;
  assign valid_o   = valid_q;
  // Bytes shift out with zero fill, so the output byte is 8'h00 whenever idle.
  assign data_o    = shreg_q[23:16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shreg_q <= data_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      shreg_q <= {shreg_q[15:0], 8'h00};
      if (last_byte) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/host_msg_handler.sv
// Host-side message handler: collects a syndrome frame from the host byte
// stream, launches the decoder core, times it and returns the result bytes.
//
// state    | meaning
// IDLE     | waiting for START_DECODING_MSG
// WAIT_HDR | waiting for MEASUREMENT_DATA_HEADER
// LOAD     | storing MEAS_BYTES syndrome bytes
// DECODE   | decoder running, cycle counter active
// RESULT   | sending iteration count and cycle count
module host_msg_handler
  import host_msg_handler_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 2,
  parameter int GRID_WIDTH_U = 5,
  localparam int BYTES_PER_ROUND      = bytes_for_bits(GRID_WIDTH_X * GRID_WIDTH_Z),
  localparam int ALIGNED_PU_PER_ROUND = 8 * BYTES_PER_ROUND,
  localparam int MEAS_BYTES           = BYTES_PER_ROUND * GRID_WIDTH_U,
  localparam int MEAS_W               = ALIGNED_PU_PER_ROUND * GRID_WIDTH_U
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        input_data,
  input  logic              input_valid,
  output logic              input_ready,
  output logic [7:0]        output_data,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [MEAS_W-1:0] measurements,
  output logic              start_decode,
  input  logic              decode_done,
  input  logic [7:0]        iteration_count
);

  localparam int CNT_W = (MEAS_BYTES > 1) ? $clog2(MEAS_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEAS_BYTES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [CNT_W+2:0]   wr_idx;
  logic [MEAS_W-1:0]  meas_q;
  logic [15:0]        cycle_q;
  logic               start_q;
  logic               in_fire;
  logic               done_seen;
  logic               ser_done;

  assign input_ready  = (state_q == IDLE) || (state_q == WAIT_HDR) || (state_q == LOAD);
  assign in_fire      = input_valid & input_ready;
  assign wr_idx       = {byte_cnt_q, 3'b000};
  // decode_done is not trusted in the launch cycle; the core may still show
  // a stale done from the previous frame.
  assign done_seen    = (state_q == DECODE) && !start_q && decode_done;
  assign measurements = meas_q;
  assign start_decode = start_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      meas_q     <= '0;
      cycle_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_fire && (input_data == START_DECODING_MSG)) state_q <= WAIT_HDR;
        end
        WAIT_HDR: begin
          if (in_fire && (input_data == MEASUREMENT_DATA_HEADER)) begin
            byte_cnt_q <= '0;
            meas_q     <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            meas_q[wr_idx +: 8] <= input_data;
            if (byte_cnt_q == LAST_CNT) begin
              state_q <= DECODE;
              start_q <= 1'b1;
              cycle_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
          end
        end
        DECODE: begin
          if (done_seen) begin
            state_q <= RESULT;
          end else if (!decode_done && (cycle_q != 16'hFFFF)) begin
            cycle_q <= cycle_q + 16'd1;
          end
        end
        RESULT: begin
          if (ser_done) state_q <= WAIT_HDR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  result_serializer u_result_serializer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (done_seen),
    .data_i  ({iteration_count, cycle_q}),
    .ready_i (output_ready),
    .valid_o (output_valid),
    .data_o  (output_data),
    .done_o  (ser_done)
  );

endmodule

// File: tb/tb_host_msg_handler.sv
// Directed bench for host_msg_handler: frame load, decode timing, result
// serialization with back-pressure, garbage rejection, saturation and reset.
module tb_host_msg_handler;
  import host_msg_handler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  input_data;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic [39:0] measurements;
  logic        start_decode;
  logic        decode_done;
  logic [7:0]  iteration_count;

  int checks   = 0;
  int failures = 0;

  host_msg_handler dut (
    .clk             (clk),
    .reset           (reset),
    .input_data      (input_data),
    .input_valid     (input_valid),
    .input_ready     (input_ready),
    .output_data     (output_data),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .measurements    (measurements),
    .start_decode    (start_decode),
    .decode_done     (decode_done),
    .iteration_count (iteration_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_input_ready"},  64'(input_ready),  64'd1);
    check({tag, "_output_valid"}, 64'(output_valid), 64'd0);
    check({tag, "_output_data"},  64'(output_data),  64'h00);
    check({tag, "_start_decode"}, 64'(start_decode), 64'd0);
    check({tag, "_measurements"}, 64'(measurements), 64'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    input_data  = b;
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    input_data  = 8'h00;
  endtask

  // Header plus five frame bytes, LSB byte of m first; optional idle gaps.
  task automatic send_frame(input logic [39:0] m, input bit gaps);
    logic [39:0] frame;
    frame = m;
    send_byte(MEASUREMENT_DATA_HEADER);
    for (int i = 0; i < 5; i++) begin
      send_byte(frame[8*i +: 8]);
      if (gaps && i < 4) begin
        input_data  = 8'hFF;
        input_valid = 1'b0;
        @(negedge clk);
        input_data  = 8'h00;
        if (i == 1) check("gap_partial_meas", 64'(measurements), {48'h0, frame[15:0]});
      end
    end
  endtask

  // Done rises after n_low low DECODE cycles; result bytes are then collected,
  // with output_ready stalled for `stall` cycles on the second byte.
  task automatic decode_and_collect(input string tag, input int n_low, input logic [7:0] iter,
                                    input int stall, input logic [7:0] e0,
                                    input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b [3];
    int pulses;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    decode_done = 1'b0;
    for (int k = 0; k < 20 && !start_decode; k++) @(negedge clk);
    check({tag, "_start_seen"}, 64'(start_decode), 64'd1);
    pulses = 1;
    for (int i = 0; i < n_low; i++) begin
      @(negedge clk);
      if (start_decode) pulses++;
    end
    check({tag, "_start_pulses"}, 64'(pulses), 64'd1);
    decode_done     = 1'b1;
    iteration_count = iter;
    output_ready    = 1'b1;
    for (int k = 0; k < 20 && !output_valid; k++) @(negedge clk);
    decode_done     = 1'b0;
    iteration_count = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 64'(output_valid), 64'd1);
      check($sformatf("%s_byte%0d", tag, i), 64'(output_data), 64'(exp_b[i]));
      if (i == 1 && stall > 0) begin
        output_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check($sformatf("%s_hold_valid%0d", tag, s), 64'(output_valid), 64'd1);
          check($sformatf("%s_hold_byte%0d", tag, s), 64'(output_data), 64'(exp_b[1]));
        end
        output_ready = 1'b1;
      end
      @(negedge clk);
    end
    check({tag, "_valid_after"}, 64'(output_valid), 64'd0);
    check({tag, "_data_after"},  64'(output_data),  64'h00);
    check({tag, "_ready_after"}, 64'(input_ready),  64'd1);
    output_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    input_data      = 8'h00;
    input_valid     = 1'b0;
    output_ready    = 1'b0;
    decode_done     = 1'b0;
    iteration_count = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);

    // Basic frame, 12 cycles to done, iteration 3 -> 03 00 0C.
    send_byte(START_DECODING_MSG);
    send_frame(40'h1008040201, 1'b0);
    check("basic_meas", 64'(measurements), 64'h1008040201);
    check("basic_ready_decode", 64'(input_ready), 64'd0);
    decode_and_collect("basic", 12, 8'h03, 0, 8'h03, 8'h00, 8'h0C);
    check("basic_meas_held", 64'(measurements), 64'h1008040201);

    // Streaming frame with 50% input_valid, then a 4-cycle stall on byte 1.
    send_frame(40'h1008040201, 1'b1);
    check("gap_meas", 64'(measurements), 64'h1008040201);
    check("gap_ready_decode", 64'(input_ready), 64'd0);
    decode_and_collect("stall", 12, 8'h07, 4, 8'h07, 8'h00, 8'h0C);

    // Garbage in IDLE and WAIT_HDR is ignored.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'hAA);
    send_byte(START_DECODING_MSG);
    send_byte(8'hAA);
    send_byte(START_DECODING_MSG);
    check("garbage_meas_untouched", 64'(measurements), 64'h0);
    send_frame(40'h5544332211, 1'b0);
    check("garbage_meas", 64'(measurements), 64'h5544332211);
    decode_and_collect("garbage", 5, 8'h2A, 0, 8'h2A, 8'h00, 8'h05);

    // Cycle counter saturation.
    send_frame(40'h0504030201, 1'b0);
    check("sat_meas", 64'(measurements), 64'h0504030201);
    decode_and_collect("sat", 70000, 8'h01, 0, 8'h01, 8'hFF, 8'hFF);

    // Reset mid-LOAD abandons the frame.
    send_byte(MEASUREMENT_DATA_HEADER);
    send_byte(8'h11);
    send_byte(8'h22);
    check("midload_partial", 64'(measurements), 64'h2211);
    reset = 1'b0;
    #1;
    check_reset_values("midload_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midload_rel");
    send_byte(START_DECODING_MSG);
    send_frame(40'h1008040201, 1'b0);
    check("fresh_meas", 64'(measurements), 64'h1008040201);
    decode_and_collect("fresh", 12, 8'h03, 0, 8'h03, 8'h00, 8'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
